qbert_move_master: RTL and testbench
====================================

Name: qbert_move_master

Overview:
- Avalon-MM master that drives the MTL controller's register map in place of the NIOS for a jump sequence.
- At reset it writes the map geometry, then sets enable=1.
- Per accepted jump command it writes qbert_jump, raises nios_start_qbert, polls done_move until the move completes, then clears nios_start_qbert.
- It connects directly to the controller's avalon_slave port on Avalon_CLK_50.

Parameters:
- XLENGTH_INIT, 11'd60, value written to address 2.
- XYDIAG_INIT, 21'h0F01E, value written to address 3.
- RANK1_OFFSET_INIT, 21'h1E190, value written to address 4.
- READ_LATENCY, 1, fixed cycles from read acceptance to valid readdata.
- POLL_GAP, 16, idle cycles between two done_move reads.
- TIMEOUT_CYC, 2000000, poll cycles before abort; used only with the optional feature.

Ports:
- Avalon_CLK_50  in  1  clock.
- iRST_n  in  1  reset, asynchronous, active-low.
- iCmd_valid  in  1  jump command valid.
- iCmd_jump  in  3  jump direction code.
- oCmd_ready  out  1  command accepted when iCmd_valid && oCmd_ready.
- iColor_valid  in  1  request to write the top-color vector.
- iTop_color  in  28  cube top-color bits.
- avm_address  out  8  slave register address.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_read  out  1  read request.
- avm_readdata  in  32  read data.
- avm_waitrequest  in  1  slave stall.
- oInit_done  out  1  init sequence complete; sticky.
- oBusy  out  1  move in progress.
- oError  out  1  timeout abort flag; sticky until next accepted command.

Behaviour:
- Reset values: all outputs 0; FSM in INIT_XL.
- Bus rules:
  - At most one of avm_write and avm_read is high at a time.
  - Address, data and strobe are held stable while avm_waitrequest=1.
  - A transfer completes on the first edge with the strobe high and avm_waitrequest=0; the strobe drops in the next cycle unless a new transfer is issued back-to-back.
  - Read data is sampled exactly READ_LATENCY cycles after acceptance.
- Write states, in order: INIT_XL (addr 2), INIT_XY (3), INIT_R1 (4), INIT_EN (0, data 1), then IDLE.
  - oInit_done rises in the cycle IDLE is entered.
- In IDLE, priority goes to command over color:
  - oCmd_ready=1 only in IDLE with oInit_done=1.
  - On handshake, iCmd_jump is latched, oBusy=1, and the FSM goes to WR_JUMP: write addr 8 = {29'b0, jump}.
  - WR_START1: write addr 9 = 1.
  - POLL_LO: read addr 11; stay until bit0==0, waiting POLL_GAP cycles between reads.
  - POLL_HI: same as POLL_LO until bit0==1.
  - WR_START0: write addr 9 = 0, then IDLE with oBusy=0.
  - The two-phase poll is mandatory: a stale done_move=1 left over from the previous move must not end the sequence.
- If iColor_valid is high in IDLE and there is no command: write addr 5 = {4'b0, iTop_color}, then return to IDLE. The color is latched at the decision cycle.
- Simultaneous command and color: the command is served first; the color request is served after the sequence if still asserted.
- Commands arriving while busy are not accepted (oCmd_ready=0) and are not queued.
- A POLL_GAP counter of ceil(log2(POLL_GAP+1)) bits reloads after each accepted read.
- Reset mid-transfer: every strobe drops asynchronously; after release, the full init sequence reruns.

Optional Feature:
- Macro QBERT_MASTER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs from WR_START1 completion through POLL_HI.
  - Reaching TIMEOUT_CYC drives the FSM to ABORT: write addr 10 = 1, then addr 9 = 0.
  - After ABORT the FSM returns to IDLE with oError=1.
  - oError clears on the next command handshake.
- Undefined: no counter is built, polling is unbounded, and oError is tied to 0.

Decomposition:
- Package qbert_avalon_pkg holds:
  - The register address localparams: A_ENABLE=0, A_ISPI=1, A_XLENGTH=2, A_XYDIAG_DEMI=3, A_RANK1_XY_OFFSET=4, A_TOP_COLOR=5, A_POS_XY0=6, A_POS_XY1=7, A_JUMP=8, A_START=9, A_BAD_JUMP=10, A_DONE_MOVE=11.
  - The FSM state enum typedef.
  - The jump code typedef (logic [2:0]).
- Sub-module avm_single_xfer owns the strobe/waitrequest/readdata-latency handshake.
  - Inputs: req, is_read, addr, wdata.
  - Outputs: done, rdata.
  - The main FSM only sequences states around it.

Test Plan:
- Reset release with waitrequest=0: writes (2,60), (3,0x0F01E), (4,0x1E190), (0,1) on consecutive transfers, then oInit_done=1.
- Waitrequest held high 5 cycles during INIT_XY: address/data stay at 3/0x0F01E for all 5 cycles; exactly one write is counted.
- Command jump=3, done_move responds 1,1,0,0,1: writes (8,3), (9,1); 5 reads of addr 11; then write (9,0); oBusy drops; oCmd_ready returns to 1.
- iCmd_valid and iColor_valid (color 0xFFFFFFF) asserted in the same IDLE cycle: the jump sequence runs first, then write (5,0x0FFFFFFF).
- iRST_n pulsed low during POLL_HI read: avm_read=0 immediately; after release, the init sequence restarts from address 2.
- With QBERT_MASTER_TIMEOUT_EN and TIMEOUT_CYC=100, done_move stuck at 0: writes (10,1), (9,0), then oError=1; the next command clears oError.

Source files
------------

// File: rtl/qbert_avalon_pkg.sv
// Register map, FSM state encodings and shared types for the Q*bert Avalon-MM master.
package qbert_avalon_pkg;

  localparam logic [7:0] A_ENABLE          = 8'd0;
  localparam logic [7:0] A_ISPI            = 8'd1;
  localparam logic [7:0] A_XLENGTH         = 8'd2;
  localparam logic [7:0] A_XYDIAG_DEMI     = 8'd3;
  localparam logic [7:0] A_RANK1_XY_OFFSET = 8'd4;
  localparam logic [7:0] A_TOP_COLOR       = 8'd5;
  localparam logic [7:0] A_POS_XY0         = 8'd6;
  localparam logic [7:0] A_POS_XY1         = 8'd7;
  localparam logic [7:0] A_JUMP            = 8'd8;
  localparam logic [7:0] A_START           = 8'd9;
  localparam logic [7:0] A_BAD_JUMP        = 8'd10;
  localparam logic [7:0] A_DONE_MOVE       = 8'd11;

  typedef logic [2:0] jump_t;

  typedef enum logic [3:0] {
    INIT_XL, INIT_XY, INIT_R1, INIT_EN, IDLE,
    WR_JUMP, WR_START1, POLL_LO, POLL_HI, WR_START0,
    WR_COLOR, ABORT_BAD, ABORT_STOP
  } state_t;

  typedef enum logic { X_REQ, X_LAT } xfer_phase_t;

endpackage

// File: rtl/qbert_move_master_if.sv
// Avalon-MM bus between the Q*bert move master and the MTL controller slave.
interface qbert_move_master_if;
  logic [7:0]  avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_write, avm_writedata, avm_read,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_write, avm_writedata, avm_read,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/avm_single_xfer.sv
// One Avalon-MM transfer at a time: strobe until waitrequest clears, then fixed read latency.
module avm_single_xfer
  import qbert_avalon_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        is_read,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  qbert_move_master_if.master avm
);
  localparam int unsigned LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  xfer_phase_t   phase_q, phase_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          strobe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= X_REQ;
      lat_q   <= '0;
    end else begin
      phase_q <= phase_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    lat_d   = lat_q;
    done    = 1'b0;
    strobe  = 1'b0;
    case (phase_q)
      X_REQ: begin
        if (req) begin
          strobe = 1'b1;
          if (!avm.avm_waitrequest) begin
            if (is_read) begin
              phase_d = X_LAT;
              lat_d   = LW'(READ_LATENCY - 1);
            end else begin
              done = 1'b1;
            end
          end
        end
      end
      X_LAT: begin
        if (lat_q == '0) begin
          done    = 1'b1;
          phase_d = X_REQ;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: phase_d = X_REQ;
    endcase
  end

  // Readdata is only meaningful on the cycle done is high in the latency phase.
  assign rdata             = avm.avm_readdata;
  assign avm.avm_write     = strobe & ~is_read;
  assign avm.avm_read      = strobe & is_read;
  assign avm.avm_address   = strobe ? addr : '0;
  assign avm.avm_writedata = (strobe & ~is_read) ? wdata : '0;

endmodule

// File: rtl/qbert_move_master.sv
// Avalon-MM master driving the MTL controller register map for Q*bert jump sequences.
// Define QBERT_MASTER_TIMEOUT_EN to build the done_move poll timeout and abort path.
module qbert_move_master
  import qbert_avalon_pkg::*;
#(
  parameter logic [10:0] XLENGTH_INIT      = 11'd60,
  parameter logic [20:0] XYDIAG_INIT       = 21'h0F01E,
  parameter logic [20:0] RANK1_OFFSET_INIT = 21'h1E190,
  parameter int unsigned READ_LATENCY      = 1,
  parameter int unsigned POLL_GAP          = 16,
  parameter int unsigned TIMEOUT_CYC       = 2000000
) (
  input  logic        Avalon_CLK_50,
  input  logic        iRST_n,
  input  logic        iCmd_valid,
  input  jump_t       iCmd_jump,
  output logic        oCmd_ready,
  input  logic        iColor_valid,
  input  logic [27:0] iTop_color,
  qbert_move_master_if.master avm,
  output logic        oInit_done,
  output logic        oBusy,
  output logic        oError
);
  localparam int unsigned GW = $clog2(POLL_GAP + 1);

  state_t        state_q, state_d;
  logic          run_q, init_done_q, busy_q;
  jump_t         jump_q;
  logic [27:0]   color_q;
  logic [GW-1:0] gap_q;
  logic          req, is_read, done;
  logic [7:0]    addr;
  logic [31:0]   wdata, rdata;
  logic          cmd_hs, color_take, poll_done, seq_end;
  logic          unused_rdata;

  assign unused_rdata = ^rdata[31:1];

  avm_single_xfer #(.READ_LATENCY(READ_LATENCY)) u_xfer (
    .clk     (Avalon_CLK_50),
    .rst_n   (iRST_n),
    .req     (req),
    .is_read (is_read),
    .addr    (addr),
    .wdata   (wdata),
    .done    (done),
    .rdata   (rdata),
    .avm     (avm)
  );

`ifdef QBERT_MASTER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_q;
  logic          to_hit, err_q;

  assign to_hit = (to_q == TW'(TIMEOUT_CYC));

  always_ff @(posedge Avalon_CLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == WR_START1 && done) to_q <= '0;
      else if ((state_q == POLL_LO || state_q == POLL_HI) && !to_hit) to_q <= to_q + 1'b1;
      if (cmd_hs) err_q <= 1'b0;
      else if (state_q == ABORT_STOP && done) err_q <= 1'b1;
    end
  end
  assign oError = err_q;
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYC;
  assign oError = 1'b0;
`endif

  assign oCmd_ready = (state_q == IDLE) && init_done_q;
  assign oInit_done = init_done_q;
  assign oBusy      = busy_q;
  assign seq_end    = (state_q == WR_START0 || state_q == ABORT_STOP) && done;

  always_comb begin
    state_d    = state_q;
    req        = 1'b0;
    is_read    = 1'b0;
    addr       = '0;
    wdata      = '0;
    cmd_hs     = 1'b0;
    color_take = 1'b0;
    poll_done  = 1'b0;
    case (state_q)
      INIT_XL: begin
        req = run_q; addr = A_XLENGTH; wdata = {21'b0, XLENGTH_INIT};
        if (done) state_d = INIT_XY;
      end
      INIT_XY: begin
        req = 1'b1; addr = A_XYDIAG_DEMI; wdata = {11'b0, XYDIAG_INIT};
        if (done) state_d = INIT_R1;
      end
      INIT_R1: begin
        req = 1'b1; addr = A_RANK1_XY_OFFSET; wdata = {11'b0, RANK1_OFFSET_INIT};
        if (done) state_d = INIT_EN;
      end
      INIT_EN: begin
        req = 1'b1; addr = A_ENABLE; wdata = 32'd1;
        if (done) state_d = IDLE;
      end
      IDLE: begin
        if (oCmd_ready && iCmd_valid) begin
          cmd_hs  = 1'b1;
          state_d = WR_JUMP;
        end else if (init_done_q && iColor_valid) begin
          color_take = 1'b1;
          state_d    = WR_COLOR;
        end
      end
      WR_JUMP: begin
        req = 1'b1; addr = A_JUMP; wdata = {29'b0, jump_q};
        if (done) state_d = WR_START1;
      end
      WR_START1: begin
        req = 1'b1; addr = A_START; wdata = 32'd1;
        if (done) state_d = POLL_LO;
      end
      // Falling edge of done_move must be seen before the rising one, so a
      // stale 1 from the previous move cannot finish this sequence.
      POLL_LO, POLL_HI: begin
        req = (gap_q == '0); is_read = 1'b1; addr = A_DONE_MOVE;
        if (done) begin
          poll_done = 1'b1;
          if (state_q == POLL_LO && !rdata[0]) state_d = POLL_HI;
          else if (state_q == POLL_HI && rdata[0]) state_d = WR_START0;
        end
`ifdef QBERT_MASTER_TIMEOUT_EN
        else if (to_hit && gap_q != '0) state_d = ABORT_BAD;
`endif
      end
      WR_START0: begin
        req = 1'b1; addr = A_START; wdata = 32'd0;
        if (done) state_d = IDLE;
      end
      WR_COLOR: begin
        req = 1'b1; addr = A_TOP_COLOR; wdata = {4'b0, color_q};
        if (done) state_d = IDLE;
      end
      ABORT_BAD: begin
        req = 1'b1; addr = A_BAD_JUMP; wdata = 32'd1;
        if (done) state_d = ABORT_STOP;
      end
      ABORT_STOP: begin
        req = 1'b1; addr = A_START; wdata = 32'd0;
        if (done) state_d = IDLE;
      end
      default: state_d = INIT_XL;
    endcase
  end

  always_ff @(posedge Avalon_CLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q     <= INIT_XL;
      run_q       <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b0;
      jump_q      <= '0;
      color_q     <= '0;
      gap_q       <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (state_q == INIT_EN && done) init_done_q <= 1'b1;
      if (cmd_hs) begin
        busy_q <= 1'b1;
        jump_q <= iCmd_jump;
      end else if (seq_end) begin
        busy_q <= 1'b0;
      end
      if (color_take) color_q <= iTop_color;
      if (poll_done) gap_q <= GW'(POLL_GAP);
      else if (cmd_hs) gap_q <= '0;
      else if (gap_q != '0) gap_q <= gap_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_qbert_move_master.sv
// Directed self-checking bench for qbert_move_master with a simple Avalon slave model.
module tb_qbert_move_master;
  import qbert_avalon_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  jump_t       cmd_jump;
  logic        cmd_ready;
  logic        color_valid;
  logic [27:0] top_color;
  logic        init_done, busy, err;

  always #5 clk = ~clk;

  qbert_move_master_if bus();

  qbert_move_master #(.TIMEOUT_CYC(100)) dut (
    .Avalon_CLK_50 (clk),
    .iRST_n        (rst_n),
    .iCmd_valid    (cmd_valid),
    .iCmd_jump     (cmd_jump),
    .oCmd_ready    (cmd_ready),
    .iColor_valid  (color_valid),
    .iTop_color    (top_color),
    .avm           (bus),
    .oInit_done    (init_done),
    .oBusy         (busy),
    .oError        (err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0]  wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  logic [7:0]  ra[$];
  logic [31:0] resp[$];
  logic [31:0] resp_default;

  always @(posedge clk) cyc++;

  // Slave model: logs accepted transfers and presents read data for the latency edge.
  always @(negedge clk) begin
    n_checks++;
    if (bus.avm_write && bus.avm_read) begin
      n_fail++;
      $display("FAIL bus_exclusive: write=%0b read=%0b, required not both", bus.avm_write, bus.avm_read);
    end
    if (!bus.avm_waitrequest) begin
      if (bus.avm_write) begin
        wa.push_back(bus.avm_address);
        wd.push_back(bus.avm_writedata);
        wc.push_back(cyc);
      end
      if (bus.avm_read) begin
        ra.push_back(bus.avm_address);
        if (resp.size() > 0) bus.avm_readdata = resp.pop_front();
        else bus.avm_readdata = resp_default;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete(); ra.delete(); resp.delete();
  endtask

  task automatic wait_init(input int budget);
    int k = 0;
    while (!init_done && k < budget) begin tick(); k++; end
    n_checks++;
    if (init_done !== 1'b1) begin
      n_fail++; $display("FAIL init_timeout: oInit_done=%0b, required 1", init_done);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin tick(); k++; end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_timeout: oBusy=%0b, required 0", busy);
    end
  endtask

  task automatic send_cmd(input jump_t j);
    cmd_valid = 1'b1; cmd_jump = j;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_writedata} !== 42'd0) begin
      n_fail++;
      $display("FAIL reset_bus: w=%0b r=%0b a=%0d d=%h, required all 0",
               bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_writedata);
    end
    n_checks++;
    if ({init_done, busy, err, cmd_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: init=%0b busy=%0b err=%0b ready=%0b, required 0000", init_done, busy, err, cmd_ready);
    end
  endtask

  task automatic test_init();
    logic [7:0]  ea[4];
    logic [31:0] ed[4];
    ea = '{8'd2, 8'd3, 8'd4, 8'd0};
    ed = '{32'd60, 32'h0000F01E, 32'h0001E190, 32'd1};
    clear_log();
    @(negedge clk) rst_n = 1'b1;
    wait_init(30);
    n_checks++;
    if (wa.size() != 4) begin
      n_fail++; $display("FAIL init_count: writes=%0d, required 4", wa.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
          n_fail++; $display("FAIL init_write%0d: (%0d,%h), required (%0d,%h)", i, wa[i], wd[i], ea[i], ed[i]);
        end
      end
      n_checks++;
      if (wc[3] - wc[0] != 3) begin
        n_fail++; $display("FAIL init_consecutive: span=%0d cycles, required 3", wc[3] - wc[0]);
      end
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL init_ready: oCmd_ready=%0b, required 1", cmd_ready);
    end
  endtask

  task automatic test_waitrequest();
    int k = 0;
    int n3 = 0;
    logic found = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    clear_log();
    @(negedge clk) rst_n = 1'b1;
    while (!found && k < 20) begin
      tick(); k++;
      if (bus.avm_write && bus.avm_address == 8'd3) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL stall_find: write to addr 3 not seen, found=%0b required 1", found);
    end
    bus.avm_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (bus.avm_write !== 1'b1 || bus.avm_address !== 8'd3 || bus.avm_writedata !== 32'h0000F01E) begin
        n_fail++;
        $display("FAIL stall_hold%0d: w=%0b a=%0d d=%h, required 1/3/0000f01e", i, bus.avm_write, bus.avm_address, bus.avm_writedata);
      end
    end
    bus.avm_waitrequest = 1'b0;
    wait_init(30);
    foreach (wa[i]) if (wa[i] == 8'd3) n3++;
    n_checks++;
    if (n3 != 1 || wa.size() != 4) begin
      n_fail++; $display("FAIL stall_count: addr3 writes=%0d total=%0d, required 1 and 4", n3, wa.size());
    end
  endtask

  task automatic test_jump();
    logic [7:0]  ea[3];
    logic [31:0] ed[3];
    ea = '{8'd8, 8'd9, 8'd9};
    ed = '{32'd3, 32'd1, 32'd0};
    clear_log();
    resp = '{32'd1, 32'd1, 32'd0, 32'd0, 32'd1};
    resp_default = 32'd1;
    tick();
    send_cmd(3'd3);
    n_checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL jump_busy: busy=%0b ready=%0b, required 1 0", busy, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_jump = 3'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (cmd_ready !== 1'b0) begin
        n_fail++; $display("FAIL busy_ready%0d: oCmd_ready=%0b, required 0", i, cmd_ready);
      end
    end
    cmd_valid = 1'b0;
    wait_idle(400);
    n_checks++;
    if (wa.size() != 3) begin
      n_fail++; $display("FAIL jump_count: writes=%0d, required 3", wa.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
          n_fail++; $display("FAIL jump_write%0d: (%0d,%h), required (%0d,%h)", i, wa[i], wd[i], ea[i], ed[i]);
        end
      end
    end
    n_checks++;
    if (ra.size() != 5) begin
      n_fail++; $display("FAIL jump_reads: reads=%0d, required 5", ra.size());
    end
    foreach (ra[i]) begin
      n_checks++;
      if (ra[i] !== 8'd11) begin
        n_fail++; $display("FAIL read_addr%0d: %0d, required 11", i, ra[i]);
      end
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL jump_ready: oCmd_ready=%0b, required 1", cmd_ready);
    end
  endtask

  task automatic test_cmd_color();
    logic [7:0]  ea[4];
    logic [31:0] ed[4];
    ea = '{8'd8, 8'd9, 8'd9, 8'd5};
    ed = '{32'd1, 32'd1, 32'd0, 32'h0FFFFFFF};
    clear_log();
    resp = '{32'd0, 32'd1};
    resp_default = 32'd1;
    color_valid = 1'b1; top_color = 28'hFFFFFFF;
    send_cmd(3'd1);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL prio_busy: oBusy=%0b, required 1", busy);
    end
    wait_idle(400);
    tick();
    color_valid = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (wa.size() != 4) begin
      n_fail++; $display("FAIL prio_count: writes=%0d, required 4", wa.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
          n_fail++; $display("FAIL prio_write%0d: (%0d,%h), required (%0d,%h)", i, wa[i], wd[i], ea[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    logic found = 1'b0;
    clear_log();
    resp = '{32'd0};
    resp_default = 32'd0;
    send_cmd(3'd2);
    while (!found && k < 200) begin
      tick(); k++;
      if (bus.avm_read && ra.size() == 1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL rstmid_find: POLL_HI read not seen, found=%0b required 1", found);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.avm_read !== 1'b0 || bus.avm_write !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_strobe: r=%0b w=%0b, required 0 0", bus.avm_read, bus.avm_write);
    end
    n_checks++;
    if (busy !== 1'b0 || init_done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_flags: busy=%0b init=%0b, required 0 0", busy, init_done);
    end
    clear_log();
    @(negedge clk) rst_n = 1'b1;
    wait_init(30);
    n_checks++;
    if (wa.size() != 4 || wa[0] !== 8'd2) begin
      n_fail++; $display("FAIL rstmid_reinit: writes=%0d first_addr=%0d, required 4 and 2", wa.size(), wa[0]);
    end
  endtask

`ifdef QBERT_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0]  ea[4];
    logic [31:0] ed[4];
    ea = '{8'd8, 8'd9, 8'd10, 8'd9};
    ed = '{32'd4, 32'd1, 32'd1, 32'd0};
    clear_log();
    resp_default = 32'd0;
    tick();
    send_cmd(3'd4);
    wait_idle(1000);
    n_checks++;
    if (wa.size() != 4) begin
      n_fail++; $display("FAIL abort_count: writes=%0d, required 4", wa.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
          n_fail++; $display("FAIL abort_write%0d: (%0d,%h), required (%0d,%h)", i, wa[i], wd[i], ea[i], ed[i]);
        end
      end
    end
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL abort_error: oError=%0b, required 1", err);
    end
    resp = '{32'd0, 32'd1};
    resp_default = 32'd1;
    send_cmd(3'd0);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL error_clear: oError=%0b, required 0", err);
    end
    wait_idle(400);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL error_after: oError=%0b, required 0", err);
    end
  endtask
`else
  task automatic test_unbounded();
    int n10 = 0;
    clear_log();
    resp_default = 32'd0;
    tick();
    send_cmd(3'd4);
    repeat (300) tick();
    foreach (wa[i]) if (wa[i] == 8'd10) n10++;
    n_checks++;
    if (busy !== 1'b1 || err !== 1'b0 || n10 != 0) begin
      n_fail++; $display("FAIL unbounded_poll: busy=%0b err=%0b abort_writes=%0d, required 1 0 0", busy, err, n10);
    end
    n_checks++;
    if (ra.size() < 2) begin
      n_fail++; $display("FAIL unbounded_reads: reads=%0d, required >=2", ra.size());
    end
    resp_default = 32'd1;
    wait_idle(200);
    n_checks++;
    if (wa.size() != 3 || wa[2] !== 8'd9 || wd[2] !== 32'd0 || err !== 1'b0) begin
      n_fail++; $display("FAIL unbounded_end: writes=%0d last=(%0d,%h) err=%0b, required 3 (9,0) 0",
                         wa.size(), wa[2], wd[2], err);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_jump = '0;
    color_valid = 1'b0;
    top_color = '0;
    bus.avm_waitrequest = 1'b0;
    resp_default = 32'd0;
    test_reset();
    test_init();
    test_waitrequest();
    test_jump();
    test_cmd_color();
    test_reset_mid();
`ifdef QBERT_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_unbounded();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
